// File: rtl/avalon_i2s_transmitter.sv
// Avalon-MM fed I2S transmitter: stereo frame FIFO, CSRs and a one-bit-delay
// serializer stepped by synchronized, edge-detected bclk/lrclk.
module avalon_i2s_transmitter #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned LOW_WATER  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        bclk_in,
  input  logic        lrclk_in,
  output logic        sd_out,
  output logic        irq
);
  localparam int unsigned     AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [8:0]      DEPTH_C = 9'(FIFO_DEPTH);
  localparam logic [8:0]      LOW_C   = 9'(LOW_WATER);

  typedef enum logic [1:0] {IDLE, WAIT_LEFT, RUN} state_t;

  logic bclk_s1_q, bclk_s2_q, bclk_prev_q, lr_s1_q, lr_s2_q;
  logic bclk_fall, left_edge, right_edge;

  state_t              state_q, state_d;
  logic                lr_prev_q, lr_prev_d;
  logic                sd_q, sd_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;

  logic [2*SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [2*SAMPLE_W-1:0] rd_word;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [8:0]            count_q, count_d;
  logic                  empty, full, push, pop;

  logic        enable_q, irq_en_q, underrun_q, overflow_q, irq_q;
  logic [31:0] rdata_q;
  logic        wr_data, wr_ctrl, flush, underrun_set, overflow_set;

  // Two-flop synchronizers plus a history flop on bclk for fall detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_prev_q <= 1'b0;
      lr_s1_q     <= 1'b0;
      lr_s2_q     <= 1'b0;
    end else begin
      bclk_s1_q   <= bclk_in;
      bclk_s2_q   <= bclk_s1_q;
      bclk_prev_q <= bclk_s2_q;
      lr_s1_q     <= lrclk_in;
      lr_s2_q     <= lr_s1_q;
    end
  end

  assign bclk_fall  = bclk_prev_q & ~bclk_s2_q;
  assign left_edge  = bclk_fall & lr_prev_q & ~lr_s2_q;
  assign right_edge = bclk_fall & ~lr_prev_q & lr_s2_q;

  assign wr_data      = avs_write & (avs_address == 2'd0);
  assign wr_ctrl      = avs_write & (avs_address == 2'd2);
  assign flush        = wr_ctrl & avs_writedata[3];
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign rd_word      = mem_q[rd_ptr_q];
  // A full FIFO still accepts a write when a pop frees a slot in the same cycle
  assign push         = wr_data & ~flush & (~full | pop);
  assign overflow_set = wr_data & ~flush & full & ~pop;

  // Serializer next state: every action is gated by a bclk falling edge,
  // except leaving IDLE/WAIT_LEFT on enable changes
  always_comb begin
    state_d      = state_q;
    lr_prev_d    = bclk_fall ? lr_s2_q : lr_prev_q;
    sd_d         = sd_q;
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    pop          = 1'b0;
    underrun_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bclk_fall) sd_d = 1'b0;
        if (enable_q)  state_d = WAIT_LEFT;
      end
      WAIT_LEFT, RUN: begin
        if (bclk_fall) sd_d = 1'b0;
        if (left_edge) begin
          if (enable_q) begin
            state_d = RUN;
            if (!empty) begin
              pop     = 1'b1;
              shreg_d = rd_word[SAMPLE_W +: SAMPLE_W];
              hold_d  = rd_word[0 +: SAMPLE_W];
            end else begin
              shreg_d      = '0;
              hold_d       = '0;
              underrun_set = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end else if (state_q == WAIT_LEFT) begin
          if (!enable_q) state_d = IDLE;
        end else if (right_edge) begin
          shreg_d = hold_q;
        end else if (bclk_fall) begin
          sd_d    = shreg_q[SAMPLE_W-1];
          shreg_d = shreg_q << 1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serializer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lr_prev_q <= 1'b0;
      sd_q      <= 1'b0;
      shreg_q   <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      lr_prev_q <= lr_prev_d;
      sd_q      <= sd_d;
      shreg_q   <= shreg_d;
      hold_q    <= hold_d;
    end
  end

  // FIFO fill level; flush overrides any push/pop in the same cycle
  always_comb begin
    count_d = count_q;
    if (flush)             count_d = '0;
    else if (push && !pop) count_d = count_q + 9'd1;
    else if (pop && !push) count_d = count_q - 9'd1;
  end

  // FIFO pointers and level; flush empties by snapping read onto write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push)      wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (flush)     rd_ptr_q <= wr_ptr_q;
      else if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // FIFO storage; contents are unobservable while the level is zero
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {avs_writedata[16 +: SAMPLE_W], avs_writedata[0 +: SAMPLE_W]};
  end

  // CSRs, sticky flags (set beats clear), registered irq and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (wr_ctrl) begin
        enable_q <= avs_writedata[0];
        irq_en_q <= avs_writedata[4];
      end
      underrun_q <= (underrun_q & ~(wr_ctrl & avs_writedata[1])) | underrun_set;
      overflow_q <= (overflow_q & ~(wr_ctrl & avs_writedata[2])) | overflow_set;
      irq_q      <= irq_en_q & enable_q & (count_q < LOW_C);
      if (avs_read) begin
        unique case (avs_address)
          2'd1:    rdata_q <= {7'b0, count_q, 11'b0, (state_q == RUN), overflow_q,
                               underrun_q, full, empty};
          2'd2:    rdata_q <= {27'b0, irq_en_q, 3'b0, enable_q};
          default: rdata_q <= '0;
        endcase
      end
    end
  end

  assign avs_readdata = rdata_q;
  assign sd_out       = sd_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_avalon_i2s_transmitter.sv
// Directed/randomized bench: frame-level queue model predicts every I2S slot,
// STATUS word and irq level.
module tb_avalon_i2s_transmitter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        bclk_in = 1'b1;
  logic        lrclk_in = 1'b1;
  logic        sd_out;
  logic        irq;

  int n_pass = 0;
  int n_total = 0;

  avalon_i2s_transmitter #(.FIFO_DEPTH(64), .SAMPLE_W(16), .LOW_WATER(16)) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .bclk_in(bclk_in), .lrclk_in(lrclk_in), .sd_out(sd_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mq[$];
  bit m_en = 0, m_irqen = 0, m_under = 0, m_over = 0, m_run = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] slot_bits(input logic [15:0] s);
    return {1'b0, s, 15'b0};
  endfunction

  function automatic logic [31:0] exp_status();
    int unsigned n = mq.size();
    logic [31:0] s = '0;
    s[0] = (n == 0);
    s[1] = (n == 64);
    s[2] = m_under;
    s[3] = m_over;
    s[4] = m_run;
    s[24:16] = 9'(n);
    return s;
  endfunction

  function automatic logic [31:0] exp_irq();
    return {31'b0, m_irqen & m_en & (mq.size() < 16)};
  endfunction

  function automatic void model_ctrl(input logic [31:0] v);
    m_en = v[0];
    m_irqen = v[4];
    if (v[1]) m_under = 0;
    if (v[2]) m_over = 0;
    if (v[3]) mq.delete();
  endfunction

  function automatic void model_frame(output logic [31:0] el, output logic [31:0] er);
    logic [31:0] w;
    el = '0;
    er = '0;
    m_run = m_en;
    if (m_en) begin
      if (mq.size() > 0) begin
        w = mq.pop_front();
        el = slot_bits(w[31:16]);
        er = slot_bits(w[15:0]);
      end else begin
        m_under = 1;
      end
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_en = 0; m_irqen = 0; m_under = 0; m_over = 0; m_run = 0;
  endfunction

  task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wr_data(input logic [31:0] w);
    avs_wr(2'd0, w);
    if (mq.size() < 64) mq.push_back(w);
    else m_over = 1;
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    avs_wr(2'd2, v);
    model_ctrl(v);
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    avs_rd(2'd1, d);
    check(tag, d, exp_status());
  endtask

  // One 64-bclk frame; optional CONTROL write or reset pulse at a given bit fall
  task automatic drive_frame(input int half, input int ctl_at, input logic [31:0] ctl_val,
                             input int rst_at, output logic [31:0] ls, output logic [31:0] rs);
    ls = '0;
    rs = '0;
    for (int b = 0; b < 64; b++) begin
      @(negedge clk);
      bclk_in = 1'b0;
      lrclk_in = (b >= 32);
      if (b == ctl_at) begin
        avs_address = 2'd2; avs_writedata = ctl_val; avs_write = 1'b1;
      end
      if (b == rst_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_sd_out", {31'b0, sd_out}, 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
      end
      for (int i = 0; i < half; i++) begin
        @(negedge clk);
        avs_write = 1'b0;
        reset_n = 1'b1;
      end
      bclk_in = 1'b1;
      if (b < 32) ls[31-b] = sd_out;
      else        rs[63-b] = sd_out;
      for (int i = 0; i < half - 1; i++) @(negedge clk);
    end
  endtask

  task automatic frame_check(input int half, input int ctl_at, input logic [31:0] ctl_val,
                             input int rst_at);
    logic [31:0] ls, rs, el, er, keep;
    model_frame(el, er);
    drive_frame(half, ctl_at, ctl_val, rst_at, ls, rs);
    if (ctl_at >= 0) model_ctrl(ctl_val);
    if (rst_at >= 0) begin
      keep = 32'hFFFF_FFFF << (32 - rst_at);
      el = el & keep;
      er = '0;
      model_reset();
    end
    check("left_slot", ls, el);
    check("right_slot", rs, er);
    check("irq", {31'b0, irq}, exp_irq());
  endtask

  initial begin
    logic [31:0] d;
    int unsigned n;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_readdata", avs_readdata, 32'd0);
    check("reset_sd_out", {31'b0, sd_out}, 32'd0);
    check("reset_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_status("reset_status");
    avs_rd(2'd2, d);
    check("reset_control", d, 32'd0);

    // Idle frame establishes the word-clock history
    frame_check(4, -1, '0, -1);

    // Basic frame at bclk = clk/16
    wr_ctrl(32'h1);
    wr_data(32'h8001_7FFE);
    frame_check(8, -1, '0, -1);
    chk_status("basic_status");

    // Random frames
    n = $urandom_range(2, 5);
    for (int i = 0; i < int'(n); i++) wr_data($urandom);
    avs_rd(2'd0, d);
    check("data_read_zero", d, 32'd0);
    for (int i = 0; i < int'(n); i++) frame_check(4, -1, '0, -1);
    chk_status("random_status");

    // Underrun, then clear it while keeping enable
    frame_check(4, -1, '0, -1);
    frame_check(4, -1, '0, -1);
    chk_status("underrun_status");
    wr_ctrl(32'h3);
    chk_status("underrun_cleared");
    avs_rd(2'd2, d);
    check("control_read", d, 32'h1);

    // Disable: block returns to IDLE at the next left boundary
    wr_ctrl(32'h0);
    frame_check(4, -1, '0, -1);
    chk_status("disabled_status");

    // Overflow: 65 writes into a 64-deep FIFO, then drain
    for (int i = 0; i < 65; i++) wr_data($urandom);
    chk_status("overflow_status");
    wr_ctrl(32'h1);
    for (int i = 0; i < 65; i++) frame_check(4, -1, '0, -1);
    chk_status("drained_status");
    wr_ctrl(32'h7);
    chk_status("flags_cleared");

    // Enable arriving mid right slot waits for the next left boundary
    wr_ctrl(32'h0);
    frame_check(4, -1, '0, -1);
    wr_data($urandom);
    wr_data($urandom);
    frame_check(4, 40, 32'h1, -1);
    chk_status("wait_left_status");
    frame_check(4, -1, '0, -1);
    frame_check(4, -1, '0, -1);

    // Low-water interrupt
    wr_ctrl(32'h08);
    for (int i = 0; i < 20; i++) wr_data($urandom);
    wr_ctrl(32'h11);
    repeat (2) @(negedge clk);
    check("irq_fill20", {31'b0, irq}, exp_irq());
    for (int i = 0; i < 5; i++) frame_check(4, -1, '0, -1);
    check("irq_fill15", {31'b0, irq}, 32'd1);
    wr_ctrl(32'h19);
    repeat (2) @(negedge clk);
    check("irq_flushed", {31'b0, irq}, 32'd1);
    chk_status("flushed_status");

    // Reset in the middle of a left slot
    wr_ctrl(32'h1);
    wr_data($urandom);
    wr_data($urandom);
    frame_check(4, -1, '0, 10);
    chk_status("post_reset_status");
    wr_data($urandom);
    frame_check(4, -1, '0, -1);
    wr_ctrl(32'h1);
    frame_check(4, -1, '0, -1);
    chk_status("final_status");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
